// File: rtl/fpga_robots_game_tm_arbiter_pkg.sv
// Shared configuration for the tile map port arbiter: tile map geometry,
// requester indices and arbiter state encodings.
package fpga_robots_game_tm_arbiter_pkg;

  // Tile map geometry (6kB map, 13-bit byte address)
  localparam int TM_AW = 13;
  localparam int TM_DW = 8;

  // Requester slots on the shared tile map port
  localparam int RQ_GAME   = 0;
  localparam int RQ_STATUS = 1;
  localparam int RQ_CLEAR  = 2;
  localparam int RQ_NUM    = 3;

  // Arbiter states: free round-robin, or one requester holding the port
  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fpga_robots_game_rr_pick.sv
// Combinational round-robin picker: selects the first active request at or
// above the pointer, wrapping modulo NREQ. Returns a one-hot vector and index.
module fpga_robots_game_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int PW = $clog2(NREQ);

  // Scan NREQ candidates starting from the pointer; the first hit wins
  always_comb begin
    int  cand;
    logic found;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt   = '0;
    idx   = '0;
    cand  = 0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/fpga_robots_game_tm_arbiter.sv
// Shares the tile map's single read/write port among NREQ requesters.
// Round-robin grant with an optional lock for read-modify-write sequences,
// a registered memory-side request, and a 2-deep one-hot response pipeline
// that steers the read data strobe back to the issuer.
module fpga_robots_game_tm_arbiter
  import fpga_robots_game_tm_arbiter_pkg::*;
#(
  parameter int NREQ     = RQ_NUM,
  parameter int AW       = TM_AW,
  parameter int DW       = TM_DW,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   rq_req,
  input  logic [NREQ-1:0]   rq_lock,
  input  logic [NREQ-1:0]   rq_wen,
  input  logic [NREQ*AW-1:0] rq_adr,
  input  logic [NREQ*DW-1:0] rq_wrt,
  output logic [NREQ-1:0]   rq_gnt,
  output logic [NREQ-1:0]   rsp_vld,
  output logic [DW-1:0]     rsp_dat,
  output logic [AW-1:0]     tm_adr,
  output logic [DW-1:0]     tm_wrt,
  output logic              tm_wen,
  input  logic [DW-1:0]     tm_red
);

  localparam int PW = $clog2(NREQ);

  arb_state_e      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [7:0]      cnt;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] rsp_pipe;
  logic            accept;

  fpga_robots_game_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req (rq_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant: round-robin pick when free, only the owner while locked
  always_comb begin
    rq_gnt  = '0;
    win_idx = pick_idx;
    if (state == ST_LOCKED) begin
      win_idx        = owner;
      rq_gnt[owner]  = rq_req[owner];
    end else begin
      rq_gnt = pick_gnt;
    end
  end

  assign accept  = |(rq_req & rq_gnt);

  // Read data goes straight back; rsp_vld tells each requester whether it is theirs
  assign rsp_dat = tm_red;

  // FSM, lock counter, memory-side request registers and response pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      tm_adr   <= '0;
      tm_wrt   <= '0;
      tm_wen   <= 1'b0;
      rsp_pipe <= '0;
      rsp_vld  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rsp_pipe <= accept ? rq_gnt : '0;
      rsp_vld  <= rsp_pipe;
      tm_wen   <= 1'b0;
      if (accept) begin
        tm_adr <= rq_adr[int'(win_idx)*AW +: AW];
        tm_wrt <= rq_wrt[int'(win_idx)*DW +: DW];
        tm_wen <= rq_wen[win_idx];
        ptr    <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
      end
      case (state)
        ST_ARB: begin
          if (accept && rq_lock[win_idx]) begin
            owner <= win_idx;
            cnt   <= 8'd1;
            state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (rq_lock[owner]) begin
            cnt <= cnt + 8'd1;
          end
          // The owner's grant equals its request, so lock low means either it
          // was just accepted as the closing access or it has gone idle.
          if (cnt == 8'(LOCK_MAX) || !rq_lock[owner]) begin
            state <= ST_ARB;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_tm_arbiter.sv
// Directed bench for the tile map arbiter with a small tile map model
// (write-through read port, registered one clock after the address).
module tb_fpga_robots_game_tm_arbiter;
  import fpga_robots_game_tm_arbiter_pkg::*;

  localparam int NREQ     = 3;
  localparam int AW       = 13;
  localparam int DW       = 8;
  localparam int LOCK_MAX = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    rq_req, rq_lock, rq_wen, rq_gnt, rsp_vld;
  logic [NREQ*AW-1:0] rq_adr;
  logic [NREQ*DW-1:0] rq_wrt;
  logic [DW-1:0]      rsp_dat, tm_wrt, tm_red;
  logic [AW-1:0]      tm_adr;
  logic               tm_wen;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [int];

  fpga_robots_game_tm_arbiter #(
    .NREQ (NREQ), .AW (AW), .DW (DW), .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rq_req  (rq_req),
    .rq_lock (rq_lock),
    .rq_wen  (rq_wen),
    .rq_adr  (rq_adr),
    .rq_wrt  (rq_wrt),
    .rq_gnt  (rq_gnt),
    .rsp_vld (rsp_vld),
    .rsp_dat (rsp_dat),
    .tm_adr  (tm_adr),
    .tm_wrt  (tm_wrt),
    .tm_wen  (tm_wen),
    .tm_red  (tm_red)
  );

  always #5 clk = ~clk;

  // Unwritten cells hold a fixed pattern: low address byte xor 8'h5A
  function automatic logic [7:0] seed(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Tile map model: write-through, read data one clock after the address
  always @(posedge clk) begin
    if (tm_wen) begin
      mem[int'(tm_adr)] = tm_wrt;
      tm_red <= tm_wrt;
    end else begin
      tm_red <= mem.exists(int'(tm_adr)) ? mem[int'(tm_adr)] : seed(tm_adr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rq_req  = '0;
    rq_lock = '0;
    rq_wen  = '0;
    rq_adr  = '0;
    rq_wrt  = '0;
  endtask

  task automatic set_rq(input int i, input logic lk, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq_req[i]          = 1'b1;
    rq_lock[i]         = lk;
    rq_wen[i]          = we;
    rq_adr[i*AW +: AW] = a;
    rq_wrt[i*DW +: DW] = d;
  endtask

  // Advance to just after the next rising edge; inputs change here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_g [6];
    logic [7:0] exp_d [3];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_d = '{8'h5F, 8'h5C, 8'h5D};

    // ---- Reset state
    clear_inputs();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_gnt",    rq_gnt,  0);
    check("rst_vld",    rsp_vld, 0);
    check("rst_tm_wen", tm_wen,  0);
    check("rst_tm_adr", tm_adr,  0);
    check("rst_tm_wrt", tm_wrt,  0);
    rst = 1'b0;

    // ---- 1: all three read back-to-back, round-robin order
    for (int k = 0; k < 8; k++) begin
      clear_inputs();
      if (k < 6) begin
        set_rq(RQ_GAME,   1'b0, 1'b0, 13'd5, 8'h00);
        set_rq(RQ_STATUS, 1'b0, 1'b0, 13'd6, 8'h00);
        set_rq(RQ_CLEAR,  1'b0, 1'b0, 13'd7, 8'h00);
      end
      #4;
      if (k < 6) check("t1_gnt", rq_gnt, exp_g[k]);
      if (k >= 1 && k <= 6) begin
        check("t1_tm_adr", tm_adr, (exp_g[k-1] == 3'b001) ? 5 : (exp_g[k-1] == 3'b010) ? 6 : 7);
        check("t1_tm_wen", tm_wen, 0);
      end
      if (k >= 2) begin
        check("t1_vld", rsp_vld, exp_g[k-2]);
        check("t1_dat", rsp_dat, exp_d[(k-2) % 3]);
      end
      tick();
    end

    // ---- 2: write then read same address, same requester
    clear_inputs();
    set_rq(RQ_GAME, 1'b0, 1'b1, 13'd100, 8'hA5);
    #4; check("t2_gnt_w", rq_gnt, 3'b001);
    tick();
    clear_inputs();
    set_rq(RQ_GAME, 1'b0, 1'b0, 13'd100, 8'h00);
    #4;
    check("t2_gnt_r",  rq_gnt, 3'b001);
    check("t2_tm_wen", tm_wen, 1);
    check("t2_tm_adr", tm_adr, 100);
    check("t2_tm_wrt", tm_wrt, 8'hA5);
    tick();
    clear_inputs();
    #4;
    check("t2_ack_vld", rsp_vld, 3'b001);
    check("t2_ack_dat", rsp_dat, 8'hA5);
    check("t2_tm_wen0", tm_wen,  0);
    tick();
    #4;
    check("t2_rd_vld", rsp_vld, 3'b001);
    check("t2_rd_dat", rsp_dat, 8'hA5);
    tick();
    #4;
    check("t2_idle_vld", rsp_vld, 0);
    tick();

    // ---- 3: locked read-modify-write by rq1 while rq0/rq2 wait
    clear_inputs();
    set_rq(RQ_GAME,   1'b0, 1'b0, 13'd10,  8'h00);
    set_rq(RQ_STATUS, 1'b1, 1'b0, 13'd200, 8'h00);
    set_rq(RQ_CLEAR,  1'b0, 1'b0, 13'd11,  8'h00);
    #4; check("t3_gnt0", rq_gnt, 3'b010);
    tick();
    clear_inputs();
    set_rq(RQ_GAME,   1'b0, 1'b0, 13'd10,  8'h00);
    set_rq(RQ_STATUS, 1'b0, 1'b1, 13'd200, 8'h3C);
    set_rq(RQ_CLEAR,  1'b0, 1'b0, 13'd11,  8'h00);
    #4; check("t3_gnt1", rq_gnt, 3'b010);
    tick();
    clear_inputs();
    set_rq(RQ_GAME,  1'b0, 1'b0, 13'd10, 8'h00);
    set_rq(RQ_CLEAR, 1'b0, 1'b0, 13'd11, 8'h00);
    #4;
    check("t3_gnt2", rq_gnt,  3'b100);
    check("t3_vld2", rsp_vld, 3'b010);
    check("t3_dat2", rsp_dat, 8'h92);
    tick();
    clear_inputs();
    set_rq(RQ_GAME, 1'b0, 1'b0, 13'd10, 8'h00);
    #4;
    check("t3_gnt3", rq_gnt,  3'b001);
    check("t3_vld3", rsp_vld, 3'b010);
    check("t3_dat3", rsp_dat, 8'h3C);
    tick();
    clear_inputs();
    #4;
    check("t3_vld4", rsp_vld, 3'b100);
    check("t3_dat4", rsp_dat, 8'h51);
    tick();
    #4;
    check("t3_vld5", rsp_vld, 3'b001);
    check("t3_dat5", rsp_dat, 8'h50);
    tick();

    // ---- 4: rq0 holds lock past LOCK_MAX while rq1 waits
    clear_inputs();
    set_rq(RQ_GAME, 1'b1, 1'b0, 13'd20, 8'h00);
    #4; check("t4_gnt_start", rq_gnt, 3'b001);
    tick();
    for (int c = 1; c <= 18; c++) begin
      clear_inputs();
      set_rq(RQ_GAME,   1'b1, 1'b0, 13'd20, 8'h00);
      set_rq(RQ_STATUS, 1'b0, 1'b0, 13'd21, 8'h00);
      #4;
      check($sformatf("t4_gnt_c%0d", c), rq_gnt, (c == 17) ? 3'b010 : 3'b001);
      tick();
    end
    clear_inputs();
    #4;
    check("t4_vld19", rsp_vld, 3'b010);
    check("t4_dat19", rsp_dat, 8'h4F);
    tick();
    #4;
    check("t4_vld20", rsp_vld, 3'b001);
    tick();

    // ---- 5: reset one cycle after a read accept
    clear_inputs();
    set_rq(RQ_GAME, 1'b0, 1'b0, 13'd7, 8'h00);
    #4; check("t5_gnt", rq_gnt, 3'b001);
    tick();
    clear_inputs();
    rst = 1'b1;
    #4; check("t5_tm_adr_pre", tm_adr, 7);
    tick();
    rst = 1'b0;
    #4;
    check("t5_vld",    rsp_vld, 0);
    check("t5_tm_wen", tm_wen,  0);
    check("t5_tm_adr", tm_adr,  0);
    check("t5_tm_wrt", tm_wrt,  0);
    check("t5_gnt0",   rq_gnt,  0);
    tick();
    set_rq(RQ_GAME,   1'b0, 1'b0, 13'd5, 8'h00);
    set_rq(RQ_STATUS, 1'b0, 1'b0, 13'd6, 8'h00);
    set_rq(RQ_CLEAR,  1'b0, 1'b0, 13'd7, 8'h00);
    #4;
    check("t5_ptr_reset", rq_gnt,  3'b001);
    check("t5_vld3",      rsp_vld, 0);
    tick();
    clear_inputs();
    #4; check("t5_vld4", rsp_vld, 0);
    tick();
    #4;
    check("t5_vld5", rsp_vld, 3'b001);
    check("t5_dat5", rsp_dat, 8'h5F);
    tick();

    // ---- 6: idle port after an out-of-map address
    clear_inputs();
    set_rq(RQ_CLEAR, 1'b0, 1'b0, 13'd8000, 8'h00);
    #4; check("t6_gnt", rq_gnt, 3'b100);
    tick();
    clear_inputs();
    for (int k = 1; k <= 10; k++) begin
      #4;
      check($sformatf("t6_tm_wen_%0d", k), tm_wen, 0);
      check($sformatf("t6_tm_adr_%0d", k), tm_adr, 8000);
      check($sformatf("t6_vld_%0d", k),    rsp_vld, (k == 2) ? 3'b100 : 3'b000);
      if (k == 2) check("t6_dat", rsp_dat, 8'h1A);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
